// File: rtl/iir_pkg.sv
// Shared constants and types for the IIR coefficient loader and its register bank.
package iir_pkg;

    localparam int unsigned W  = 16;   // coefficient width
    localparam int unsigned NB = 21;   // b0..b20
    localparam int unsigned NA = 14;   // a1..a14
    localparam int unsigned AW = 6;    // write address width
    localparam int unsigned OW = 4;    // order width

    localparam logic [AW-1:0] ADDR_B0    = 6'd0;
    localparam logic [AW-1:0] ADDR_A1    = 6'd21;
    localparam logic [AW-1:0] ADDR_ORDER = 6'd35;

    localparam logic [OW-1:0] ORDER_MIN = 4'd1;
    localparam logic [OW-1:0] ORDER_MAX = 4'd14;

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StFlush
    } state_t;

endpackage

// File: rtl/iir_coef_bank.sv
// Shadow coefficient bank with a word write port and a parallel load into the active bank.
module iir_coef_bank
    import iir_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [W-1:0]     wr_data,
    input  logic             load,
    output logic [OW-1:0]    shadow_order,
    output logic [NB*W-1:0]  b_coef,
    output logic [NA*W-1:0]  a_coef,
    output logic [OW-1:0]    order
);

    logic [W-1:0]    shb_q [NB];
    logic [W-1:0]    sha_q [NA];
    logic [OW-1:0]   sho_q;
    logic [NB*W-1:0] b_act_q;
    logic [NA*W-1:0] a_act_q;
    logic [OW-1:0]   ord_act_q;

    // Shadow bank: one word per accepted write; out-of-range addresses match nothing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NB; i++) shb_q[i] <= '0;
            for (int i = 0; i < NA; i++) sha_q[i] <= '0;
            sho_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_addr == AW'(int'(ADDR_B0) + i)) shb_q[i] <= wr_data;
            end
            for (int i = 0; i < NA; i++) begin
                if (wr_addr == AW'(int'(ADDR_A1) + i)) sha_q[i] <= wr_data;
            end
            if (wr_addr == ADDR_ORDER) sho_q <= wr_data[OW-1:0];
        end
    end

    // Active bank: whole-bank copy of the shadow so the cascade never sees a mixed set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            b_act_q   <= '0;
            a_act_q   <= '0;
            ord_act_q <= '0;
        end else if (load) begin
            for (int i = 0; i < NB; i++) b_act_q[i*W +: W] <= shb_q[i];
            for (int i = 0; i < NA; i++) a_act_q[i*W +: W] <= sha_q[i];
            ord_act_q <= sho_q;
        end
    end

    assign shadow_order = sho_q;
    assign b_coef       = b_act_q;
    assign a_coef       = a_act_q;
    assign order        = ord_act_q;

endmodule

// File: rtl/iir_coef_loader.sv
// Coefficient loader: shadow writes, validated commit at a sample boundary, cascade flush.
module iir_coef_loader
    import iir_pkg::*;
#(
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [W-1:0]     wr_data,
    input  logic             commit,
    input  logic             sample_en,
    output logic [NB*W-1:0]  b_coef,
    output logic [NA*W-1:0]  a_coef,
    output logic [OW-1:0]    order,
    output logic             filt_rst_n,
    output logic             busy,
    output logic             err
);

    localparam int unsigned CntW = $clog2(FLUSH_CYC + 1);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wr_ready_q, busy_q;
    logic            err_q, err_d;
    logic            filt_rst_n_q, filt_rst_n_d;
    logic            wr_acc;
    logic            load;
    logic [OW-1:0]   shadow_order;
    logic [OW-1:0]   order_eff;

    iir_coef_bank u_bank (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_acc),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .load         (load),
        .shadow_order (shadow_order),
        .b_coef       (b_coef),
        .a_coef       (a_coef),
        .order        (order)
    );

    // Next-state, validation and flush counting.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        filt_rst_n_d = filt_rst_n_q;
        load         = 1'b0;
        wr_acc       = wr_valid && wr_ready_q;
        // A write in the commit cycle lands first, so validate the post-write order.
        order_eff    = (wr_acc && wr_addr == ADDR_ORDER) ? wr_data[OW-1:0] : shadow_order;

        if (wr_acc && wr_addr > ADDR_ORDER) err_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (commit) begin
                    if (order_eff >= ORDER_MIN && order_eff <= ORDER_MAX) begin
                        state_d = StPend;
                        err_d   = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            StPend: begin
                if (sample_en) begin
                    load         = 1'b1;
                    cnt_d        = CntW'(FLUSH_CYC);
                    filt_rst_n_d = 1'b0;
                    state_d      = StFlush;
                end
            end
            StFlush: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    filt_rst_n_d = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; filt_rst_n holds low from reset until a flush completes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            wr_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            filt_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ready_q   <= (state_d == StIdle);
            busy_q       <= (state_d != StIdle);
            err_q        <= err_d;
            filt_rst_n_q <= filt_rst_n_d;
        end
    end

    assign wr_ready   = wr_ready_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign filt_rst_n = filt_rst_n_q;

endmodule
